// File: rtl/md_sched_ctrl.sv
// md_sched_ctrl: multiply/divide sequencer for the E stage.
// Tracks the latency of an in-flight mult/div with a two-state FSM and a
// down-counter. It raises a one-cycle HI/LO commit strobe on the last busy
// cycle and generates MDStall, which holds the D stage while an instruction
// there that touches HI/LO would race the unit.
//
// Handshake: the unit has no valid/ready pair. EStartMul/EStartDiv act as
// "valid" for a start. The unit accepts a start only in IDLE and only when
// Req is low. MDStall is the back-pressure: it keeps any HI/LO user in D
// from entering E until the cycle after HLWe, so a second start can never
// arrive while the unit is still running.
module md_sched_ctrl #(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10,
   parameter int CNT_W      = 4
) (
   input  logic Clk,
   input  logic Reset,
   input  logic Req,
   input  logic EStartMul,
   input  logic EStartDiv,
   input  logic EWriteHL,
   input  logic DUsesMD,
   output logic Busy,
   output logic BusyOp,
   output logic HLWe,
   output logic MDStall,
   output logic fsm_state
);

   localparam logic IDLE = 1'b0;
   localparam logic RUN  = 1'b1;

   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

   logic             state;
   logic [CNT_W-1:0] count;
   logic             start;
   logic [CNT_W-1:0] load_val;
   logic             unused_ewritehl;

   // mthi/mtlo has no sequential effect; its collision with a busy unit is
   // prevented upstream by MDStall.
   assign unused_ewritehl = EWriteHL;

   // Accept a new operation only when idle and not being flushed.
   always_comb begin
      start    = (EStartMul | EStartDiv) & ~Req & (state == IDLE);
      load_val = EStartDiv ? DIV_LOAD : MUL_LOAD;
   end

   // Stall D while a HI/LO user there could race a running or starting op.
   always_comb begin
      MDStall = DUsesMD & (Busy | EStartMul | EStartDiv);
   end

   assign fsm_state = state;

   // FSM, latency counter and registered Busy/BusyOp/HLWe outputs.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state  <= IDLE;
         count  <= '0;
         Busy   <= 1'b0;
         BusyOp <= 1'b0;
         HLWe   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               HLWe <= 1'b0;
               if (start) begin
                  state  <= RUN;
                  count  <= load_val;
                  Busy   <= 1'b1;
                  BusyOp <= EStartDiv;
                  // A single-cycle op commits in its only busy cycle.
                  HLWe   <= (load_val == CNT_ONE);
               end
            end
            RUN: begin
               if (count == CNT_ONE) begin
                  // Last busy cycle just ended; the commit strobe has fired.
                  state <= IDLE;
                  Busy  <= 1'b0;
                  HLWe  <= 1'b0;
               end else begin
                  count <= count - CNT_ONE;
                  // Strobe lands in the cycle where the count reads 1.
                  HLWe  <= (count == CNT_TWO);
               end
            end
            default: begin
               state <= IDLE;
               Busy  <= 1'b0;
               HLWe  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_md_sched_ctrl.sv
// Directed bench for md_sched_ctrl: mult/div latency, HLWe timing, MDStall,
// flush interaction and asynchronous reset in the middle of an operation.
module tb_md_sched_ctrl;

   logic Clk = 1'b0;
   logic Reset = 1'b1;
   logic Req = 1'b0;
   logic EStartMul = 1'b0;
   logic EStartDiv = 1'b0;
   logic EWriteHL = 1'b0;
   logic DUsesMD = 1'b0;
   logic Busy, BusyOp, HLWe, MDStall, fsm_state;

   int vectors = 0;
   int miscompares = 0;

   md_sched_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
      .Clk(Clk), .Reset(Reset), .Req(Req), .EStartMul(EStartMul),
      .EStartDiv(EStartDiv), .EWriteHL(EWriteHL), .DUsesMD(DUsesMD),
      .Busy(Busy), .BusyOp(BusyOp), .HLWe(HLWe), .MDStall(MDStall),
      .fsm_state(fsm_state)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs just after the edge, check at the negedge,
   // then advance to just after the next rising edge.
   task automatic cyc(input logic mul, input logic div, input logic req,
                      input logic uses, input string tag, input logic e_busy,
                      input logic e_op, input logic e_hl, input logic e_stall);
      EStartMul = mul;
      EStartDiv = div;
      Req       = req;
      DUsesMD   = uses;
      @(negedge Clk);
      chk({tag, ".busy"}, Busy, e_busy);
      chk({tag, ".hlwe"}, HLWe, e_hl);
      chk({tag, ".stall"}, MDStall, e_stall);
      chk({tag, ".state"}, fsm_state, e_busy);
      if (e_busy) chk({tag, ".op"}, BusyOp, e_op);
      @(posedge Clk);
      #1;
   endtask

   initial begin
      // Reset state; MDStall still follows inputs while in reset.
      EStartMul = 1'b1;
      DUsesMD   = 1'b1;
      #2;
      chk("rst.busy", Busy, 1'b0);
      chk("rst.op", BusyOp, 1'b0);
      chk("rst.hlwe", HLWe, 1'b0);
      chk("rst.stall_on", MDStall, 1'b1);
      DUsesMD = 1'b0;
      #1;
      chk("rst.stall_off", MDStall, 1'b0);
      @(posedge Clk);
      #1;
      chk("rst.hold_busy", Busy, 1'b0);
      EStartMul = 1'b0;
      Reset     = 1'b0;

      // mult at t with mflo waiting in D.
      cyc(1, 0, 0, 1, "mul_t", 0, 0, 0, 1);
      for (int i = 1; i <= 4; i++) cyc(0, 0, 0, 1, "mul_run", 1, 0, 0, 1);
      cyc(0, 0, 0, 1, "mul_t5", 1, 0, 1, 1);
      cyc(0, 0, 0, 1, "mul_t6", 0, 0, 0, 0);

      // div at t, no HI/LO user in D; a start in the HLWe cycle is ignored.
      cyc(0, 1, 0, 0, "div_t", 0, 0, 0, 0);
      for (int i = 1; i <= 9; i++) cyc(0, 0, 0, 0, "div_run", 1, 1, 0, 0);
      cyc(1, 0, 0, 0, "div_t10", 1, 1, 1, 0);
      cyc(0, 0, 0, 0, "div_t11", 0, 0, 0, 0);
      cyc(0, 0, 0, 0, "div_t12", 0, 0, 0, 0);

      // Flush cancels a same-cycle start.
      cyc(1, 0, 1, 1, "req_kill_t", 0, 0, 0, 1);
      cyc(0, 0, 0, 1, "req_kill_t1", 0, 0, 0, 0);
      EWriteHL = 1'b1;
      cyc(0, 0, 0, 0, "req_kill_t2", 0, 0, 0, 0);
      EWriteHL = 1'b0;

      // Flush during a running div does not abort it.
      cyc(0, 1, 0, 0, "divreq_t", 0, 0, 0, 0);
      cyc(0, 0, 0, 0, "divreq_t1", 1, 1, 0, 0);
      cyc(0, 0, 0, 0, "divreq_t2", 1, 1, 0, 0);
      cyc(0, 0, 1, 0, "divreq_t3", 1, 1, 0, 0);
      for (int i = 4; i <= 9; i++) cyc(0, 0, 0, 0, "divreq_run", 1, 1, 0, 0);
      cyc(0, 0, 0, 0, "divreq_t10", 1, 1, 1, 0);
      cyc(0, 0, 0, 0, "divreq_t11", 0, 0, 0, 0);

      // Asynchronous reset in the middle of cycle t+2 of a div.
      cyc(0, 1, 0, 0, "rstmid_t", 0, 0, 0, 0);
      cyc(0, 0, 0, 0, "rstmid_t1", 1, 1, 0, 0);
      #2;
      Reset = 1'b1;
      #1;
      chk("rstmid.busy", Busy, 1'b0);
      chk("rstmid.op", BusyOp, 1'b0);
      chk("rstmid.hlwe", HLWe, 1'b0);
      chk("rstmid.state", fsm_state, 1'b0);
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0, "rstmid_after", 0, 0, 0, 0);

      // mult, then div held in D by the stall, issued the cycle after HLWe.
      cyc(1, 0, 0, 1, "b2b_t", 0, 0, 0, 1);
      for (int i = 1; i <= 4; i++) cyc(0, 0, 0, 1, "b2b_mul", 1, 0, 0, 1);
      cyc(0, 0, 0, 1, "b2b_t5", 1, 0, 1, 1);
      cyc(0, 1, 0, 0, "b2b_t6", 0, 0, 0, 0);
      for (int i = 7; i <= 15; i++) cyc(0, 0, 0, 0, "b2b_div", 1, 1, 0, 0);
      cyc(0, 0, 0, 0, "b2b_t16", 1, 1, 1, 0);
      cyc(0, 0, 0, 0, "b2b_t17", 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
